// File: rtl/serial_bus_arbiter.sv
// Round-robin arbiter for four shift-register peripherals sharing one serial
// data line: grants a word, shifts it out MSB first, then strobes that client's latch.
module serial_bus_arbiter #(
  parameter int WIDTH        = 16,
  parameter int LATCH_CYCLES = 1
) (
  input  logic               i_CLK,
  input  logic               i_RESET,
  input  logic [3:0]         i_Req,
  input  logic [4*WIDTH-1:0] i_Data,
  output logic [3:0]         o_Ack,
  output logic [1:0]         o_Grant,
  output logic               o_Busy,
  output logic               o_SerData,
  output logic [3:0]         o_Latch
);

  localparam int CNT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int LCNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

  state_t              state_p0, state_nxt;
  logic [1:0]          last_p0;
  logic [1:0]          grant_p0;
  logic [WIDTH-1:0]    shreg_p0;
  logic [CNT_W-1:0]    bit_cnt_p0;
  logic [LCNT_W-1:0]   lat_cnt_p0;
  logic                ser_p0;

  logic [1:0]          sel;
  logic                grant_en;
  logic [3:0]          ack;
  logic [WIDTH-1:0]    word_sel;

  // First requester after the last served client, wrapping so it comes last.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] k;
    rr_pick = last;
    for (int i = 4; i >= 1; i--) begin
      k = last + 2'(i);
      if (req[k]) rr_pick = k;
    end
  endfunction

  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) state_p0 <= IDLE;
    else         state_p0 <= state_nxt;
  end

  always_comb begin
    state_nxt = state_p0;
    grant_en  = 1'b0;
    ack       = 4'b0000;
    sel       = rr_pick(i_Req, last_p0);
    word_sel  = i_Data[sel*WIDTH +: WIDTH];
    case (state_p0)
      IDLE: begin
        if (|i_Req) begin
          grant_en  = 1'b1;
          ack       = 4'b0001 << sel;
          state_nxt = SHIFT;
        end
      end
      SHIFT: if (bit_cnt_p0 == '0) state_nxt = LATCH;
      LATCH: if (lat_cnt_p0 == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture on grant; ser_p0 already holds the MSB when SHIFT starts.
  always_ff @(posedge i_CLK or posedge i_RESET) begin
    if (i_RESET) begin
      last_p0    <= 2'd3;
      grant_p0   <= 2'd0;
      shreg_p0   <= '0;
      bit_cnt_p0 <= '0;
      lat_cnt_p0 <= '0;
      ser_p0     <= 1'b0;
    end else begin
      case (state_p0)
        IDLE: begin
          if (grant_en) begin
            shreg_p0   <= {word_sel[WIDTH-2:0], 1'b0};
            ser_p0     <= word_sel[WIDTH-1];
            grant_p0   <= sel;
            last_p0    <= sel;
            bit_cnt_p0 <= CNT_W'(WIDTH - 1);
          end
        end
        SHIFT: begin
          if (bit_cnt_p0 != '0) begin
            ser_p0     <= shreg_p0[WIDTH-1];
            shreg_p0   <= {shreg_p0[WIDTH-2:0], 1'b0};
            bit_cnt_p0 <= bit_cnt_p0 - 1'b1;
          end else begin
            ser_p0     <= 1'b0;
            lat_cnt_p0 <= LCNT_W'(LATCH_CYCLES - 1);
          end
        end
        LATCH: begin
          if (lat_cnt_p0 != '0) lat_cnt_p0 <= lat_cnt_p0 - 1'b1;
        end
        default: ser_p0 <= 1'b0;
      endcase
    end
  end

  // Ack is suppressed while reset is held so no client is acked into a cleared block.
  assign o_Ack     = i_RESET ? 4'b0000 : ack;
  assign o_Grant   = grant_p0;
  assign o_Busy    = (state_p0 != IDLE);
  assign o_SerData = ser_p0;
  assign o_Latch   = (state_p0 == LATCH) ? (4'b0001 << grant_p0) : 4'b0000;

endmodule
